// File: rtl/tx_fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tx_fifo_drain_ctrl
// Purpose  : Drains a fixed number of words from a TX FIFO and hands them, one
//            at a time, to a QSPI shifter over a valid/ready pair. Each word
//            takes FETCH (pop) -> LOAD (capture) -> HOLD (handshake). Stalls
//            on an empty FIFO are bounded by STALL_LIMIT, after which the
//            transfer ends with an underrun pulse.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            start, xfer_len   - transfer request and word count (IDLE only)
//            abort             - drop the current transfer
//            fifo_empty        - FIFO empty flag
//            fifo_rd_data      - FIFO data, valid the cycle after fifo_rd_en
//            fifo_rd_en        - FIFO pop strobe
//            out_data/out_valid/out_ready - word handshake to the shifter
//            busy              - controller not in IDLE
//            done, underrun    - single-cycle completion / stall-timeout pulses
// Revision : 1.0 - initial release
// ============================================================================
module tx_fifo_drain_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 16,
  parameter int STALL_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  xfer_len,
  input  logic                  abort,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  // The stall counter only has to reach STALL_LIMIT-1.
  localparam int                   C_STALL_W    = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [C_STALL_W-1:0] C_STALL_LAST = C_STALL_W'(STALL_LIMIT - 1);
  localparam logic [C_STALL_W-1:0] C_STALL_ONE  = C_STALL_W'(1);
  localparam logic [LEN_WIDTH-1:0] C_LEN_ONE    = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q;
  logic [LEN_WIDTH-1:0]    remaining_q;
  logic [C_STALL_W-1:0]    stall_cnt_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    out_valid_q;
  logic                    done_q;
  logic                    underrun_q;

  // Pop only while fetching and only when a word exists; FETCH lasts exactly
  // one cycle once the FIFO is non-empty, so each word is popped once.
  assign fifo_rd_en = (state_q == S_FETCH) && !fifo_empty;
  assign busy       = (state_q != S_IDLE);
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign underrun   = underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      stall_cnt_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      // Status pulses default low so each lasts a single cycle.
      done_q     <= 1'b0;
      underrun_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            remaining_q <= xfer_len;
            stall_cnt_q <= '0;
            state_q     <= (xfer_len == '0) ? S_DONE : S_FETCH;
          end
        end

        S_FETCH: begin
          if (abort) begin
            out_valid_q <= 1'b0;
            remaining_q <= '0;
            stall_cnt_q <= '0;
            state_q     <= S_IDLE;
          end else if (!fifo_empty) begin
            stall_cnt_q <= '0;
            state_q     <= S_LOAD;
          end else if (stall_cnt_q == C_STALL_LAST) begin
            stall_cnt_q <= '0;
            remaining_q <= '0;
            underrun_q  <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            stall_cnt_q <= stall_cnt_q + C_STALL_ONE;
          end
        end

        S_LOAD: begin
          if (abort) begin
            // The word popped in FETCH is dropped here.
            out_valid_q <= 1'b0;
            remaining_q <= '0;
            state_q     <= S_IDLE;
          end else begin
            out_data_q  <= fifo_rd_data;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (abort) begin
            out_valid_q <= 1'b0;
            remaining_q <= '0;
            state_q     <= S_IDLE;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            if (remaining_q != '0) begin
              remaining_q <= remaining_q - C_LEN_ONE;
            end
            // remaining_q cannot be 0 here in normal flow; treating it as the
            // last word keeps the counter from ever wrapping.
            state_q <= (remaining_q <= C_LEN_ONE) ? S_DONE : S_FETCH;
          end
        end

        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_fifo_drain_ctrl
// Purpose  : Self-checking bench for tx_fifo_drain_ctrl. A FIFO model feeds
//            the DUT; expected words and transfer outcomes are queued when
//            stimulus is issued and a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_fifo_drain_ctrl;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int SL = 4;

  logic          clk          = 1'b0;
  logic          rst_n        = 1'b1;
  logic          start        = 1'b0;
  logic [LW-1:0] xfer_len     = '0;
  logic          abort        = 1'b0;
  logic          fifo_empty   = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          out_ready    = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic          underrun;

  tx_fifo_drain_ctrl #(
    .DATA_WIDTH  (DW),
    .LEN_WIDTH   (LW),
    .STALL_LIMIT (SL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .xfer_len     (xfer_len),
    .abort        (abort),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic void chk(input bit ok, input string nm,
                              input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic void chk_eq(input string nm, input logic [63:0] act, input logic [63:0] req);
    chk(act === req, nm, act, req);
  endfunction

  // ---------------- reference model state ----------------
  typedef struct {
    bit und;   // outcome is underrun rather than done
    int acc;   // total words accepted by the shifter when the outcome fires
  } rec_t;

  logic [DW-1:0] fq[$];   // words sitting in the FIFO
  logic [DW-1:0] eq[$];   // words expected at the shifter, in order
  rec_t          xq[$];   // expected transfer outcomes, in order
  int            model_acc = 0;

  task automatic push_rec(input bit und);
    rec_t r;
    r.und = und;
    r.acc = model_acc;
    xq.push_back(r);
  endtask

  // ---------------- environment drivers ----------------
  bit rand_ready = 0;
  bit rand_gap   = 0;
  bit ready_dir  = 1;
  int gap_run    = 0;

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_dir;
    // Random empty gaps never exceed two cycles, well below the stall limit.
    if (rand_gap && gap_run < 2 && $urandom_range(0, 3) == 0) begin
      gap_run++;
      fifo_empty = 1'b1;
    end else begin
      gap_run    = 0;
      fifo_empty = (fq.size() == 0);
    end
  end

  // FIFO read port: data appears after the pop and stays through the next
  // cycle, otherwise it is garbage.
  bit keep = 0;
  always @(negedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() != 0) fifo_rd_data = fq.pop_front();
      keep = 1;
    end else if (keep) begin
      keep = 0;
    end else begin
      fifo_rd_data = $urandom;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int            acc_cnt = 0, rd_cnt = 0, val_cnt = 0;
  int            done_cyc = -1, und_cyc = -1;
  int            rd_cyc[$];
  int            acc_cyc[$];
  bit            hold_prev = 0, done_prev = 0, und_prev = 0;
  logic [DW-1:0] hold_data = '0;
  logic [DW-1:0] mon_w;
  rec_t          mon_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 0;
      done_prev = 0;
      und_prev  = 0;
    end else begin
      if (fifo_rd_en) begin
        rd_cnt++;
        rd_cyc.push_back(cyc);
        chk_eq("rd_en_while_empty", fifo_empty, 1'b0);
      end
      if (out_valid) val_cnt++;
      if (hold_prev) begin
        chk_eq("hold_valid", out_valid, 1'b1);
        chk_eq("hold_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        acc_cnt++;
        acc_cyc.push_back(cyc);
        chk(eq.size() != 0, "word_expected", out_data, 0);
        if (eq.size() != 0) begin
          mon_w = eq.pop_front();
          chk_eq("out_word", out_data, mon_w);
        end
      end
      if (done || underrun) begin
        chk_eq("busy_at_end", busy, 1'b0);
        chk_eq("done_and_underrun", done & underrun, 1'b0);
        chk(xq.size() != 0, "end_expected", done, underrun);
        if (xq.size() != 0) begin
          mon_r = xq.pop_front();
          chk_eq("end_is_underrun", underrun, mon_r.und);
          chk_eq("end_word_count", acc_cnt, mon_r.acc);
        end
        if (done)     done_cyc = cyc;
        if (underrun) und_cyc  = cyc;
      end
      if (done)     chk_eq("done_one_cycle", done_prev, 1'b0);
      if (underrun) chk_eq("underrun_one_cycle", und_prev, 1'b0);
      done_prev = done;
      und_prev  = underrun;
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // which: 0 done, 1 underrun, 2 out_valid, 3 fifo_rd_en
  task automatic wait_for(input int which, input int limit, input string nm);
    bit seen = 0;
    for (int n = 0; n < limit && !seen; n++) begin
      @(negedge clk);
      case (which)
        0:       seen = done;
        1:       seen = underrun;
        2:       seen = out_valid;
        default: seen = fifo_rd_en;
      endcase
    end
    chk(seen, nm, 0, 1);
  endtask

  task automatic do_start(input int len, output int n_edge);
    @(negedge clk);
    start    = 1'b1;
    xfer_len = LW'(len);
    @(posedge clk);
    #1;
    start    = 1'b0;
    xfer_len = '0;
    n_edge   = cyc;
  endtask

  task automatic load_words(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fq.push_back(w);
      eq.push_back(w);
    end
  endtask

  task automatic run_xfer(input int len);
    bit seen = 0;
    int n    = 0;
    load_words(len);
    model_acc += len;
    push_rec(1'b0);
    @(negedge clk);
    start    = 1'b1;
    xfer_len = LW'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1;
      end else if (busy && $urandom_range(0, 7) == 0) begin
        // A start while busy must be ignored.
        start    = 1'b1;
        xfer_len = LW'($urandom_range(1, 9));
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    chk(seen, "xfer_done_timeout", n, 400);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_edge, r0, a0, v0, v, k;

    #3 rst_n = 1'b0;
    #1;
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_rd_en", fifo_rd_en, 1'b0);
    chk_eq("rst_out_valid", out_valid, 1'b0);
    chk_eq("rst_out_data", out_data, '0);
    chk_eq("rst_done", done, 1'b0);
    chk_eq("rst_underrun", underrun, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Three words, shifter always ready: latency, throughput, done timing.
    load_words(3);
    model_acc += 3;
    push_rec(1'b0);
    r0 = rd_cnt;
    a0 = acc_cyc.size();
    do_start(3, n_edge);
    wait_for(0, 60, "abc_done_timeout");
    @(posedge clk); #1;
    chk_eq("abc_rd_pulses", rd_cnt - r0, 3);
    chk_eq("abc_rd1_cycle", qget(rd_cyc, r0), n_edge);
    chk_eq("abc_rd2_cycle", qget(rd_cyc, r0 + 1), n_edge + 3);
    chk_eq("abc_rd3_cycle", qget(rd_cyc, r0 + 2), n_edge + 6);
    chk_eq("abc_valid1_cycle", qget(acc_cyc, a0), n_edge + 2);
    chk_eq("abc_valid2_cycle", qget(acc_cyc, a0 + 1), n_edge + 5);
    chk_eq("abc_valid3_cycle", qget(acc_cyc, a0 + 2), n_edge + 8);
    chk_eq("abc_done_cycle", done_cyc, n_edge + 10);

    // Zero-length transfer: done only, nothing popped or presented.
    push_rec(1'b0);
    r0 = rd_cnt;
    v0 = val_cnt;
    do_start(0, n_edge);
    wait_for(0, 10, "zero_done_timeout");
    @(posedge clk); #1;
    chk_eq("zero_done_cycle", done_cyc, n_edge + 1);
    chk_eq("zero_no_pop", rd_cnt, r0);
    chk_eq("zero_no_valid", val_cnt, v0);

    // Empty FIFO: underrun after SL FETCH cycles, no pops.
    push_rec(1'b1);
    r0 = rd_cnt;
    do_start(2, n_edge);
    wait_for(1, 20, "underrun_timeout");
    @(posedge clk); #1;
    chk_eq("underrun_cycle", und_cyc, n_edge + SL);
    chk_eq("underrun_no_pop", rd_cnt, r0);
    chk_eq("underrun_idle", busy, 1'b0);

    // Shifter back-pressure for five cycles in HOLD.
    ready_dir = 0;
    @(posedge clk);
    load_words(1);
    model_acc += 1;
    push_rec(1'b0);
    do_start(1, n_edge);
    wait_for(2, 20, "bp_valid_timeout");
    v = cyc;
    chk_eq("bp_valid_latency", v, n_edge + 2);
    repeat (5) @(posedge clk);
    #1 ready_dir = 1;
    wait_for(0, 20, "bp_done_timeout");
    @(posedge clk); #1;
    chk_eq("bp_accept_cycle", qget(acc_cyc, acc_cyc.size() - 1), v + 5);

    // Abort while loading word 2 of 4, then drain the remainder.
    load_words(4);
    model_acc += 1;
    do_start(4, n_edge);
    k = 0;
    for (int n = 0; n < 60 && k < 2; n++) begin
      @(negedge clk);
      if (fifo_rd_en) k++;
    end
    chk_eq("abort_second_pop", k, 2);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk_eq("abort_out_valid", out_valid, 1'b0);
    chk_eq("abort_busy", busy, 1'b0);
    chk_eq("abort_fifo_left", fq.size(), 2);
    if (eq.size() != 0) void'(eq.pop_front());
    repeat (5) @(negedge clk);
    model_acc += 2;
    push_rec(1'b0);
    do_start(2, n_edge);
    wait_for(0, 40, "post_abort_done_timeout");

    // Reset while holding a word: everything clears at once, no done later.
    ready_dir = 0;
    @(posedge clk);
    load_words(2);
    do_start(2, n_edge);
    wait_for(2, 20, "rst_hold_valid_timeout");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("midrst_out_valid", out_valid, 1'b0);
    chk_eq("midrst_out_data", out_data, '0);
    chk_eq("midrst_busy", busy, 1'b0);
    chk_eq("midrst_rd_en", fifo_rd_en, 1'b0);
    chk_eq("midrst_done", done, 1'b0);
    chk_eq("midrst_underrun", underrun, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    fq.delete();
    eq.delete();
    ready_dir = 1;
    repeat (8) @(negedge clk);
    chk_eq("midrst_stays_idle", busy, 1'b0);

    // Randomized transfers with random back-pressure and short FIFO gaps.
    rand_ready = 1;
    rand_gap   = 1;
    for (int t = 0; t < 40; t++) begin
      run_xfer($urandom_range(0, 6));
    end
    rand_ready = 0;
    rand_gap   = 0;
    repeat (6) @(negedge clk);
    chk_eq("final_words_left", eq.size(), 0);
    chk_eq("final_outcomes_left", xq.size(), 0);
    chk_eq("final_fifo_left", fq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/tx_fifo_drain_ctrl.md
TX_FIFO_DRAIN_CTRL -- requirements
Module: tx_fifo_drain_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, FIFO word and output data width.
REQ-002 Parameter LEN_WIDTH, default 16, width of transfer word count.
REQ-003 Parameter STALL_LIMIT, default 255, max consecutive FETCH cycles with FIFO empty before underrun.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-007 xfer_len  input  LEN_WIDTH  number of words to drain; sampled with start.
REQ-008 abort  input  1  terminate current transfer.
REQ-009 fifo_empty  input  1  FIFO empty flag.
REQ-010 fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-011 fifo_rd_en  output  1  FIFO pop strobe.
REQ-012 out_data  output  DATA_WIDTH  word presented to QSPI shifter.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  shifter accepts out_data.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse on normal completion.
REQ-017 underrun  output  1  one-cycle pulse when STALL_LIMIT is reached.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, LOAD, HOLD, DONE.
REQ-019 IDLE: start && xfer_len!=0 -> FETCH; remaining loaded with xfer_len; stall_cnt cleared.
REQ-020 IDLE: start && xfer_len==0 -> DONE (no FIFO pop, no out_valid).
REQ-021 FETCH: fifo_rd_en = !fifo_empty (combinational, only in FETCH); if !fifo_empty -> LOAD, stall_cnt cleared.
REQ-022 FETCH with fifo_empty: stall_cnt increments; when stall_cnt==STALL_LIMIT-1 and still empty -> IDLE, underrun pulses next cycle.
REQ-023 LOAD: out_data <= fifo_rd_data, out_valid <= 1 -> HOLD.
REQ-024 HOLD: out_valid and out_data held stable until out_ready; on out_ready, out_valid <= 0, remaining decrements.
REQ-025 HOLD with out_ready: remaining==1 -> DONE, else -> FETCH.
REQ-026 DONE: done=1 for exactly one cycle -> IDLE.
REQ-027 Latency: start accepted at edge N with FIFO non-empty -> fifo_rd_en high in cycle N+1, out_valid high after edge N+2.
REQ-028 Throughput: one word per 3 cycles with out_ready held high.
REQ-029 abort in FETCH, LOAD or HOLD -> IDLE next edge; out_valid <= 0; done and underrun not pulsed; a word already popped is discarded.
REQ-030 abort has priority over all other transitions; abort in IDLE or DONE is ignored (DONE still pulses).
REQ-031 start while busy SHALL be ignored.
REQ-032 fifo_rd_en SHALL never assert while fifo_empty=1 and at most once per word.
REQ-033 remaining SHALL be LEN_WIDTH wide and SHALL never wrap below 0.

Reset
REQ-034 rst_n low SHALL force, asynchronously, state=IDLE, remaining=0, stall_cnt=0, out_data=0, out_valid=0, done=0, underrun=0.
REQ-035 fifo_rd_en and busy SHALL be 0 during reset.
REQ-036 Reset mid-transfer SHALL discard the transfer without a done or underrun pulse.

Verification
REQ-037 FIFO holds 3 words A,B,C, start xfer_len=3, out_ready=1 -> out_data A,B,C in order, 3 fifo_rd_en pulses, done one cycle after C accepted.
REQ-038 start xfer_len=0 -> done pulse 2 cycles later, fifo_rd_en and out_valid never high.
REQ-039 FIFO empty, start xfer_len=2, STALL_LIMIT=4 -> no fifo_rd_en, underrun pulse after 4 FETCH cycles, busy low after.
REQ-040 out_ready low 5 cycles in HOLD -> out_valid and out_data stable 5 cycles; word accepted on 6th.
REQ-041 abort in LOAD of word 2 of 4 -> IDLE next edge, out_valid 0, no done; new start then drains correctly.
REQ-042 rst_n asserted in HOLD -> all outputs 0 immediately, no done pulse after release.
